regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 8x16 register file; shares its single WrEn/RdEn/Address/WrData port.
- Sits between two client blocks and the register file.
- Guarantees WrEn and RdEn are never asserted together, and each strobe is exactly one cycle wide.
- Returns read data and a completion acknowledge per requester.

Parameters:
- DATA_WIDTH, 16, register-file word width.
- ADDR_WIDTH, 3, register-file address width (8 entries).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- Req0  in  1  requester 0 command request, level.
- Wr0  in  1  requester 0 command type: 1=write, 0=read.
- Addr0  in  ADDR_WIDTH  requester 0 address.
- WData0  in  DATA_WIDTH  requester 0 write data.
- Ack0  out  1  requester 0 completion, one-cycle pulse.
- RData0  out  DATA_WIDTH  requester 0 read result; valid with Ack0 and held after.
- Req1, Wr1, Addr1, WData1, Ack1, RData1: same as the requester 0 ports, for requester 1.
- WrEn  out  1  register-file write strobe.
- RdEn  out  1  register-file read strobe.
- Address  out  ADDR_WIDTH  register-file address.
- WrData  out  DATA_WIDTH  register-file write data.
- RdData  in  DATA_WIDTH  register-file read data; registered, valid in the cycle after the RdEn cycle.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, sampled on a CLK edge with RST=0:
  - state=IDLE, last_gnt=1 (requester 0 wins the first tie).
  - WrEn=RdEn=0, Address=0, WrData=0.
  - Ack0=Ack1=0, RData0=RData1=0, Busy=0.
  - Reset mid-operation aborts the command: no strobe in the next cycle and no Ack is issued.
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - Req0/Req1 are sampled only in this state.
  - One requester active: grant it.
  - Both active: grant the requester not equal to last_gnt.
  - On a grant: latch gnt id, Wr, Addr and WData into a command register; update last_gnt; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Address and WrData driven from the command register.
  - WrEn=1 if a write, otherwise RdEn=1.
  - Next state: a write goes to ACK; a read goes to CAPTURE.
- CAPTURE (reads only, 1 cycle): RdData is loaded into the granted requester's RData register at the end of the cycle; next state ACK.
- ACK (1 cycle): Ack of the granted requester =1; next state IDLE.
- Outputs: Ack, WrEn and RdEn are Moore outputs of the state and command registers.
- Address and WrData:
  - Driven from the command register in ISSUE.
  - Hold their last value in all other states.
  - WrData is forced to 0 for reads.
- Latency, with the request sampled in IDLE at cycle N:
  - Strobe in cycle N+1.
  - Write Ack in cycle N+2.
  - Read Ack in cycle N+3, with RData valid in N+3.
- Throughput: one command every 3 cycles (write) or 4 cycles (read).
- Requester protocol:
  - Hold Req and the command fields stable until Ack.
  - Drop Req in the cycle after Ack.
  - Req still high in the IDLE cycle after Ack is taken as a new command.
- Command changes after grant are ignored (already latched).
- The non-granted requester waits; its Req is held and served next.
- Strict alternation under continuous contention; no starvation.
- RDataX keeps its value across that requester's writes and the other requester's commands; it changes only on its own read capture.
- Never WrEn&RdEn=1; never more than one Ack high in a cycle.
- Address wrap: none; ADDR_WIDTH bits are passed through, so all 8 entries are reachable.

Test Plan:
- Reset with RST=0 for 2 cycles, then release -> all outputs 0, Busy=0; RdData ignored.
- Req0 write Addr0=3 WData0=0x1234 -> WrEn=1, Address=3, WrData=0x1234 in N+1; Ack0 pulse in N+2; RdEn never high.
- Then Req1 read Addr1=3 -> RdEn=1 in N+1; Ack1 and RData1=0x1234 in N+3; RData0 remains 0.
- Req0 and Req1 both held with writes to addr 1 (0x00AA) and addr 2 (0x00BB) from reset -> requester 0 served first, then 1; reads back give 0x00AA and 0x00BB. Continuous dual reads over 6 commands -> Acks strictly alternate.
- Req0 read granted, RST=0 asserted during CAPTURE -> next cycle IDLE, no Ack0, RData0=0, strobes 0.
- Req0 held high across its Ack (write 0xFFFF to addr 7) -> second identical write issued starting in the IDLE cycle after ACK; this confirms the new-command rule; no WrEn/RdEn overlap at any cycle.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared 8x16 register file port.
// Each command is issued as a single one-cycle WrEn or RdEn strobe, and completion
// is reported with a one-cycle Ack to the requester that issued it.
module regfile_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Req0,
    input  logic                  Wr0,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0] WData0,
    output logic                  Ack0,
    output logic [DATA_WIDTH-1:0] RData0,
    input  logic                  Req1,
    input  logic                  Wr1,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic                  Ack1,
    output logic [DATA_WIDTH-1:0] RData1,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    output logic                  Busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  gnt_q, gnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  sel;

    // State, command and read-result registers; reset aborts any command in flight.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Arbitration in IDLE, command sequencing and read-data capture.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        // On contention, the requester not served last wins; otherwise the lone requester.
        sel        = (Req0 && Req1) ? ~last_gnt_q : Req1;
        unique case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    gnt_d      = sel;
                    last_gnt_d = sel;
                    wr_d       = sel ? Wr1 : Wr0;
                    addr_d     = sel ? Addr1 : Addr0;
                    // Reads carry zero write data so WrData is 0 while RdEn is up.
                    wdata_d    = (sel ? Wr1 : Wr0) ? (sel ? WData1 : WData0) : '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = wr_q ? ACK : CAPTURE;
            end
            CAPTURE: begin
                if (gnt_q) rdata1_d = RdData;
                else       rdata0_d = RdData;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs; Address/WrData mirror the command register, which only changes on a grant.
    always_comb begin
        WrEn    = (state_q == ISSUE) && wr_q;
        RdEn    = (state_q == ISSUE) && !wr_q;
        Ack0    = (state_q == ACK) && !gnt_q;
        Ack1    = (state_q == ACK) && gnt_q;
        Address = addr_q;
        WrData  = wdata_q;
        RData0  = rdata0_q;
        RData1  = rdata1_q;
        Busy    = (state_q != IDLE);
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a registered-read register file model.
module tb_regfile_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  wr  = '0;
    logic [2:0]  addr  [2];
    logic [15:0] wdata [2];
    logic        Ack0, Ack1, WrEn, RdEn, Busy;
    logic [15:0] RData0, RData1, WrData, RdData;
    logic [2:0]  Address;

    typedef struct packed {
        logic        id;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
    } cmd_t;

    cmd_t        sb[$];
    logic [15:0] ref_mem [8];
    logic [15:0] rf_mem  [8];
    logic [15:0] rf_rd = '0;
    logic [15:0] rd_exp0 = '0, rd_exp1 = '0;
    logic        prev_strobe = 1'b0;
    int          strobe_cyc = 0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    regfile_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .CLK(CLK), .RST(RST),
        .Req0(req[0]), .Wr0(wr[0]), .Addr0(addr[0]), .WData0(wdata[0]),
        .Ack0(Ack0), .RData0(RData0),
        .Req1(req[1]), .Wr1(wr[1]), .Addr1(addr[1]), .WData1(wdata[1]),
        .Ack1(Ack1), .RData1(RData1),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    assign RdData = rf_rd;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (WrEn === 1'b1) rf_mem[Address] <= WrData;
        if (RdEn === 1'b1) rf_rd <= rf_mem[Address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic id, input logic w, input logic [2:0] a, input logic [15:0] d);
        cmd_t e;
        e.id = id; e.wr = w; e.addr = a;
        if (w) begin
            ref_mem[a] = d;
            e.data = d;
        end else begin
            e.data = ref_mem[a];
        end
        sb.push_back(e);
    endtask

    // Monitor: strobes and Acks are checked against the head of the scoreboard.
    always @(negedge CLK) begin
        if (RST !== 1'b1) begin
            rd_exp0     <= '0;
            rd_exp1     <= '0;
            prev_strobe <= 1'b0;
        end else begin
            check("wr_rd_excl", {31'b0, WrEn & RdEn}, 0);
            check("ack_excl", {31'b0, Ack0 & Ack1}, 0);
            if (WrEn || RdEn) begin
                check("strobe_width", {31'b0, prev_strobe}, 0);
                check("busy_on_strobe", {31'b0, Busy}, 1);
                if (sb.size() == 0) check("spurious_strobe", 1, 0);
                else begin
                    check("strobe_kind", {31'b0, WrEn}, {31'b0, sb[0].wr});
                    check("strobe_addr", {29'b0, Address}, {29'b0, sb[0].addr});
                    check("strobe_wdata", {16'b0, WrData}, sb[0].wr ? {16'b0, sb[0].data} : 32'd0);
                end
                strobe_cyc <= cyc;
            end
            prev_strobe <= WrEn | RdEn;
            if (Ack0 || Ack1) begin
                if (sb.size() == 0) check("spurious_ack", 1, 0);
                else begin
                    cmd_t        e;
                    logic [15:0] e0, e1;
                    e  = sb.pop_front();
                    e0 = (!e.wr && !e.id) ? e.data : rd_exp0;
                    e1 = (!e.wr &&  e.id) ? e.data : rd_exp1;
                    check("ack_id", {31'b0, Ack1}, {31'b0, e.id});
                    check("ack_latency", cyc - strobe_cyc, e.wr ? 1 : 2);
                    check("rdata0", {16'b0, RData0}, {16'b0, e0});
                    check("rdata1", {16'b0, RData1}, {16'b0, e1});
                    rd_exp0 <= e0;
                    rd_exp1 <= e1;
                end
            end
        end
    end

    task automatic do_reset();
        RST = 1'b0;
        req = '0;
        sb.delete();
        repeat (2) @(negedge CLK);
        check("rst_wren", {31'b0, WrEn}, 0);
        check("rst_rden", {31'b0, RdEn}, 0);
        check("rst_addr", {29'b0, Address}, 0);
        check("rst_wrdata", {16'b0, WrData}, 0);
        check("rst_acks", {30'b0, Ack1, Ack0}, 0);
        check("rst_rdata0", {16'b0, RData0}, 0);
        check("rst_rdata1", {16'b0, RData1}, 0);
        check("rst_busy", {31'b0, Busy}, 0);
        RST = 1'b1;
    endtask

    task automatic wait_ack(input int id, output int c);
        bit got = 0;
        c = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if ((id == 0 && Ack0) || (id == 1 && Ack1)) begin
                got = 1; c = cyc; break;
            end
        end
        if (!got) check("ack_timeout", 0, 1);
    endtask

    task automatic serve(input int id, input logic w, input logic [2:0] a, input logic [15:0] d);
        int c;
        wr[id] = w; addr[id] = a; wdata[id] = d; req[id] = 1'b1;
        wait_ack(id, c);
        req[id] = 1'b0;
    endtask

    task automatic idle_wait();
        bit got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (!Busy) begin got = 1; break; end
        end
        if (!got) check("idle_timeout", 0, 1);
    endtask

    // Request driven in an IDLE cycle: strobe must follow in the very next cycle.
    task automatic timed_cmd(input int id, input logic w, input logic [2:0] a, input logic [15:0] d);
        int c0;
        idle_wait();
        push(id[0], w, a, d);
        c0 = cyc;
        serve(id, w, a, d);
        check("req_to_strobe", strobe_cyc - c0, 1);
    endtask

    initial begin
        int c1, c2;
        bit got;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = '0;
            rf_mem[i]  = '0;
        end
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        do_reset();
        timed_cmd(0, 1'b1, 3'd3, 16'h1234);
        timed_cmd(1, 1'b0, 3'd3, 16'h0000);

        do_reset();
        push(0, 1'b1, 3'd1, 16'h00AA);
        push(1, 1'b1, 3'd2, 16'h00BB);
        fork
            serve(0, 1'b1, 3'd1, 16'h00AA);
            serve(1, 1'b1, 3'd2, 16'h00BB);
        join
        push(0, 1'b0, 3'd1, 16'h0);
        push(1, 1'b0, 3'd2, 16'h0);
        fork
            serve(0, 1'b0, 3'd1, 16'h0);
            serve(1, 1'b0, 3'd2, 16'h0);
        join
        push(0, 1'b0, 3'd1, 16'h0); push(1, 1'b0, 3'd2, 16'h0);
        push(0, 1'b0, 3'd2, 16'h0); push(1, 1'b0, 3'd3, 16'h0);
        push(0, 1'b0, 3'd3, 16'h0); push(1, 1'b0, 3'd1, 16'h0);
        fork
            begin
                serve(0, 1'b0, 3'd1, 16'h0);
                serve(0, 1'b0, 3'd2, 16'h0);
                serve(0, 1'b0, 3'd3, 16'h0);
            end
            begin
                serve(1, 1'b0, 3'd2, 16'h0);
                serve(1, 1'b0, 3'd3, 16'h0);
                serve(1, 1'b0, 3'd1, 16'h0);
            end
        join

        // Reset during CAPTURE of a read: the command must vanish without an Ack.
        idle_wait();
        push(0, 1'b0, 3'd7, 16'h0);
        wr[0] = 1'b0; addr[0] = 3'd7; req[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (RdEn) begin got = 1; break; end
        end
        if (!got) check("abort_rden_timeout", 0, 1);
        @(negedge CLK);
        RST = 1'b0;
        req = '0;
        sb.delete();
        @(negedge CLK);
        check("abort_busy", {31'b0, Busy}, 0);
        check("abort_ack0", {31'b0, Ack0}, 0);
        check("abort_rdata0", {16'b0, RData0}, 0);
        check("abort_strobes", {30'b0, WrEn, RdEn}, 0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort_still_idle", {31'b0, Busy}, 0);

        // Req0 held through its Ack: a second identical write is taken from the next IDLE.
        idle_wait();
        push(0, 1'b1, 3'd7, 16'hFFFF);
        push(0, 1'b1, 3'd7, 16'hFFFF);
        wr[0] = 1'b1; addr[0] = 3'd7; wdata[0] = 16'hFFFF; req[0] = 1'b1;
        wait_ack(0, c1);
        wait_ack(0, c2);
        req[0] = 1'b0;
        check("rearm_ack_gap", c2 - c1, 3);
        repeat (3) @(negedge CLK);
        check("sb_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
